// File: rtl/spi_sram_responder.sv
// SPI/SQI serial-SRAM responder (23LC1024 READ/WRITE/EQIO/RSTIO subset, sequential mode, mode 0)
// serving a byte-wide synchronous backing memory.
module spi_sram_responder #(
    parameter int unsigned ADDR_BITS   = 17,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 sck,
    input  logic                 cs_n,
    input  logic [3:0]           sio_in,
    output logic [3:0]           sio_out,
    output logic [3:0]           sio_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [7:0]           mem_rdata,
    output logic                 quad_mode
);

    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    // Input synchronizers; cs_n resets to deselected.
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [3:0]             sio_sync [SYNC_STAGES];
    logic                   sck_d;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_d    <= 1'b0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sio_sync[i] <= 4'h0;
            end
        end else begin
            sck_sync[0] <= sck;
            cs_sync[0]  <= cs_n;
            sio_sync[0] <= sio_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sck_sync[i] <= sck_sync[i-1];
                cs_sync[i]  <= cs_sync[i-1];
                sio_sync[i] <= sio_sync[i-1];
            end
            sck_d <= sck_sync[SYNC_STAGES-1];
        end
    end

    logic       sck_s;
    logic       cs_s;
    logic [3:0] sio_s;
    logic       sck_rise;
    logic       sck_fall;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sio_s    = sio_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [23:0]          rx_sh, rx_n;
    logic [7:0]           tx_sh, tx_n;
    logic [7:0]           pf_byte, pf_n;
    logic                 rd_valid, rd_valid_n;
    logic                 is_read, is_read_n;
    logic                 quad_n;
    logic [3:0]           sio_out_n, sio_oe_n;
    logic [ADDR_BITS-1:0] addr_n;
    logic [7:0]           wdata_n;
    logic                 we_n, re_n;

    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] cnt_inc;
    logic [23:0]      rx_shift;

    assign step     = quad_mode ? CNT_W'(4) : CNT_W'(1);
    assign cnt_inc  = CNT_W'(cnt + step);
    assign rx_shift = quad_mode ? {rx_sh[19:0], sio_s} : {rx_sh[22:0], sio_s[0]};

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= ST_CMD;
            cnt       <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            pf_byte   <= '0;
            rd_valid  <= 1'b0;
            is_read   <= 1'b0;
            quad_mode <= 1'b0;
            sio_out   <= 4'h0;
            sio_oe    <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rx_sh     <= rx_n;
            tx_sh     <= tx_n;
            pf_byte   <= pf_n;
            rd_valid  <= rd_valid_n;
            is_read   <= is_read_n;
            quad_mode <= quad_n;
            sio_out   <= sio_out_n;
            sio_oe    <= sio_oe_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_we    <= we_n;
            mem_re    <= re_n;
        end
    end

    logic [7:0] byte_sel;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rx_n       = rx_sh;
        tx_n       = tx_sh;
        pf_n       = pf_byte;
        rd_valid_n = mem_re;
        is_read_n  = is_read;
        quad_n     = quad_mode;
        sio_out_n  = sio_out;
        sio_oe_n   = sio_oe;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        we_n       = 1'b0;
        re_n       = 1'b0;
        byte_sel   = tx_sh;

        // Memory read data lands in the prefetch buffer one cycle after mem_re.
        if (rd_valid) begin
            pf_n = mem_rdata;
        end
        if (mem_we) begin
            addr_n = mem_addr + ADDR_BITS'(1);
        end

        if (cs_s) begin
            state_n   = ST_CMD;
            cnt_n     = '0;
            sio_oe_n  = 4'h0;
            sio_out_n = 4'h0;
        end else begin
            case (state)
                ST_CMD: begin
                    if (sck_rise) begin
                        rx_n = rx_shift;
                        if (cnt_inc == CNT_W'(8)) begin
                            cnt_n = '0;
                            case (rx_shift[7:0])
                                8'h03: begin
                                    is_read_n = 1'b1;
                                    state_n   = ST_ADDR;
                                end
                                8'h02: begin
                                    is_read_n = 1'b0;
                                    state_n   = ST_ADDR;
                                end
                                8'h38: begin
                                    quad_n  = 1'b1;
                                    state_n = ST_IGNORE;
                                end
                                8'hFF: begin
                                    quad_n  = 1'b0;
                                    state_n = ST_IGNORE;
                                end
                                default: state_n = ST_IGNORE;
                            endcase
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        rx_n = rx_shift;
                        if (cnt_inc == CNT_W'(24)) begin
                            cnt_n  = '0;
                            addr_n = rx_shift[ADDR_BITS-1:0];
                            if (is_read) begin
                                re_n    = 1'b1;
                                state_n = quad_mode ? ST_DUMMY : ST_RDATA;
                            end else begin
                                state_n = ST_WDATA;
                            end
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise) begin
                        if (cnt_inc == CNT_W'(8)) begin
                            cnt_n   = '0;
                            state_n = ST_RDATA;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                ST_RDATA: begin
                    // Byte boundary: take the prefetched byte and fetch the following one.
                    if (sck_fall) begin
                        cnt_n    = (cnt_inc == CNT_W'(8)) ? '0 : cnt_inc;
                        sio_oe_n = quad_mode ? 4'b1111 : 4'b0010;
                        if (cnt == '0) begin
                            byte_sel = pf_byte;
                            addr_n   = mem_addr + ADDR_BITS'(1);
                            re_n     = 1'b1;
                        end
                        if (quad_mode) begin
                            sio_out_n = byte_sel[7:4];
                            tx_n      = {byte_sel[3:0], 4'h0};
                        end else begin
                            sio_out_n = {2'b00, byte_sel[7], 1'b0};
                            tx_n      = {byte_sel[6:0], 1'b0};
                        end
                    end
                end
                ST_WDATA: begin
                    if (sck_rise) begin
                        rx_n = rx_shift;
                        if (cnt_inc == CNT_W'(8)) begin
                            cnt_n   = '0;
                            wdata_n = rx_shift[7:0];
                            we_n    = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Scoreboard bench for spi_sram_responder: an initiator drives random SPI/SQI transactions,
// a reference model predicts memory writes and read bytes, a monitor compares them.
module tb_spi_sram_responder;

    localparam int unsigned ADDR_BITS = 17;
    localparam int unsigned HALF      = 6;

    logic                 clock = 1'b0;
    logic                 resetb;
    logic                 sck;
    logic                 cs_n;
    logic [3:0]           sio_in;
    logic [3:0]           sio_out;
    logic [3:0]           sio_oe;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_wdata;
    logic                 mem_we;
    logic                 mem_re;
    logic [7:0]           mem_rdata;
    logic                 quad_mode;

    spi_sram_responder #(.ADDR_BITS(ADDR_BITS), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .resetb    (resetb),
        .sck       (sck),
        .cs_n      (cs_n),
        .sio_in    (sio_in),
        .sio_out   (sio_out),
        .sio_oe    (sio_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .quad_mode (quad_mode)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [7:0]           data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] got_rd[$];
    logic [7:0] wq[$];
    logic [7:0] sram_w [int];
    logic [7:0] ref_w  [int];
    int         total = 0;
    int         bad   = 0;
    int         n_we  = 0;
    int         n_re  = 0;
    bit         tb_quad = 1'b0;

    // Power-up contents: fixed bytes at the wrap boundary, an address hash elsewhere.
    function automatic logic [7:0] init_val(input logic [ADDR_BITS-1:0] a);
        if (a == '1) return 8'h11;
        if (a == '0) return 8'h22;
        return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] sram_rd(input logic [ADDR_BITS-1:0] a);
        return sram_w.exists(int'(a)) ? sram_w[int'(a)] : init_val(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [ADDR_BITS-1:0] a);
        return ref_w.exists(int'(a)) ? ref_w[int'(a)] : init_val(a);
    endfunction

    always @(posedge clock) begin
        if (mem_we) sram_w[int'(mem_addr)] = mem_wdata;
        if (mem_re) mem_rdata <= sram_rd(mem_addr);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes memory or a read byte is captured.
    always @(negedge clock) begin
        if (resetb === 1'b1) begin
            if (mem_we && mem_re) check("we_re_overlap", 32'(1), 32'(0));
            if (mem_re) n_re++;
            if (mem_we) begin
                n_we++;
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (got_rd.size() != 0) begin
                logic [7:0] g;
                g = got_rd.pop_front();
                if (exp_rd.size() == 0) check("unexpected_rdata", 32'(g), 32'hFFFF_FFFF);
                else check("rdata", 32'(g), 32'(exp_rd.pop_front()));
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clocks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic sck_cycle(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
        sio_in = din;
        clocks(HALF);
        dout = sio_out;
        oe   = sio_oe;
        sck  = 1'b1;
        clocks(HALF);
        sck  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [3:0] oe_or);
        logic [3:0] d, oe;
        oe_or = 4'h0;
        if (tb_quad) begin
            for (int i = 1; i >= 0; i--) begin
                sck_cycle(b[i*4 +: 4], d, oe);
                oe_or |= oe;
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                sck_cycle({3'($urandom), b[i]}, d, oe);
                oe_or |= oe;
            end
        end
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic oe_ok);
        logic [3:0] d, oe, oe_exp;
        oe_exp = tb_quad ? 4'b1111 : 4'b0010;
        oe_ok  = 1'b1;
        b      = 8'h00;
        if (tb_quad) begin
            for (int i = 1; i >= 0; i--) begin
                sck_cycle(4'($urandom), d, oe);
                b[i*4 +: 4] = d;
                if (oe !== oe_exp) oe_ok = 1'b0;
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                sck_cycle(4'($urandom), d, oe);
                b[i] = d[1];
                if (oe !== oe_exp) oe_ok = 1'b0;
            end
        end
    endtask

    task automatic begin_tx();
        cs_n = 1'b0;
        clocks(4);
    endtask

    task automatic end_tx();
        clocks(2);
        cs_n = 1'b1;
        clocks(6);
        check("idle_oe", 32'(sio_oe), 32'(0));
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        logic [3:0] oe, acc;
        send_byte(cmd, acc);
        for (int i = 2; i >= 0; i--) begin
            send_byte(addr[i*8 +: 8], oe);
            acc |= oe;
        end
        check("hdr_oe", 32'(acc), 32'(0));
    endtask

    task automatic xfer_write(input logic [23:0] addr, input int n);
        logic [ADDR_BITS-1:0] a;
        logic [7:0]           d;
        logic [3:0]           oe;
        a = addr[ADDR_BITS-1:0];
        begin_tx();
        send_hdr(8'h02, addr);
        for (int i = 0; i < n; i++) begin
            d = (wq.size() != 0) ? wq.pop_front() : 8'($urandom);
            exp_wr.push_back(wr_t'{addr: a, data: d});
            ref_w[int'(a)] = d;
            send_byte(d, oe);
            a = a + 1'b1;
        end
        end_tx();
    endtask

    task automatic xfer_read(input logic [23:0] addr, input int n);
        logic [ADDR_BITS-1:0] a;
        logic [7:0]           b;
        logic [3:0]           oe;
        logic                 ok;
        a = addr[ADDR_BITS-1:0];
        begin_tx();
        send_hdr(8'h03, addr);
        if (tb_quad) begin
            send_byte(8'($urandom), oe);
            check("dummy_oe", 32'(oe), 32'(0));
        end
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(ref_rd(a));
            recv_byte(b, ok);
            got_rd.push_back(b);
            check("rdata_oe", 32'(ok), 32'(1));
            a = a + 1'b1;
        end
        end_tx();
    endtask

    task automatic mode_cmd(input logic [7:0] cmd);
        logic [3:0] oe;
        begin_tx();
        send_byte(cmd, oe);
        check("mode_oe", 32'(oe), 32'(0));
        end_tx();
        if (cmd == 8'h38) tb_quad = 1'b1;
        if (cmd == 8'hFF) tb_quad = 1'b0;
        check("quad_mode", 32'(quad_mode), 32'(tb_quad));
    endtask

    initial begin
        logic [3:0] d, oe, acc;
        int         we0, re0;

        resetb = 1'b0;
        cs_n   = 1'b1;
        sck    = 1'b0;
        sio_in = 4'h0;
        clocks(5);
        check("rst_oe", 32'(sio_oe), 32'(0));
        check("rst_out", 32'(sio_out), 32'(0));
        check("rst_quad", 32'(quad_mode), 32'(0));
        check("rst_strobes", 32'({mem_we, mem_re}), 32'(0));
        check("rst_addr", 32'(mem_addr), 32'(0));
        resetb = 1'b1;
        clocks(5);

        // Basic SPI write then read-back.
        wq.push_back(8'hA5);
        wq.push_back(8'h3C);
        xfer_write(24'h000010, 2);
        xfer_read(24'h000010, 2);

        // Read across the top of the array.
        xfer_read(24'h01FFFF, 2);

        // Unknown command: lanes stay released, no memory traffic.
        we0 = n_we;
        re0 = n_re;
        begin_tx();
        send_byte(8'h9F, acc);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'($urandom), oe);
            acc |= oe;
        end
        check("unknown_oe", 32'(acc), 32'(0));
        end_tx();
        check("unknown_we", 32'(n_we), 32'(we0));
        check("unknown_re", 32'(n_re), 32'(re0));

        // Write aborted 5 bits into the second byte: only the first byte lands.
        wq.push_back(8'h5A);
        begin_tx();
        send_hdr(8'h02, 24'h000400);
        exp_wr.push_back(wr_t'{addr: 17'h00400, data: 8'h5A});
        ref_w[int'(17'h00400)] = 8'h5A;
        send_byte(wq.pop_front(), oe);
        for (int i = 0; i < 5; i++) sck_cycle(4'($urandom), d, oe);
        end_tx();
        xfer_read(24'h000400, 2);

        // SQI: enter quad, write and read at 0x20, leave quad.
        mode_cmd(8'h38);
        xfer_write(24'h000020, 2);
        xfer_read(24'h000020, 2);
        mode_cmd(8'hFF);

        // Random traffic in both modes, addresses with junk above the array width.
        for (int it = 0; it < 14; it++) begin
            case ($urandom_range(0, 3))
                0: xfer_write(24'($urandom), int'($urandom_range(1, 4)));
                1: xfer_read(24'($urandom), int'($urandom_range(1, 4)));
                2: mode_cmd(($urandom_range(0, 1) != 0) ? 8'h38 : 8'hFF);
                default: xfer_read({7'($urandom), 17'h1FFFE}, 3);
            endcase
        end

        // Asynchronous reset in the middle of an SQI read.
        if (!tb_quad) mode_cmd(8'h38);
        begin_tx();
        send_hdr(8'h03, 24'h000100);
        send_byte(8'($urandom), oe);
        sck_cycle(4'($urandom), d, oe);
        check("pre_rst_oe", 32'(sio_oe), 32'hF);
        #3;
        resetb = 1'b0;
        #1;
        check("async_rst_oe", 32'(sio_oe), 32'(0));
        check("async_rst_quad", 32'(quad_mode), 32'(0));
        tb_quad = 1'b0;
        cs_n = 1'b1;
        clocks(3);
        resetb = 1'b1;
        clocks(4);
        xfer_read(24'h000010, 2);

        clocks(20);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'(0));
        check("rd_queue_empty", 32'(exp_rd.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
